// File: rtl/ifid_pipe_buffer.sv
// IF/ID pipeline buffer: two-entry (main + skid) valid/ready FIFO between fetch and decode,
// with flush for taken branches and field decode of the head instruction.
module ifid_pipe_buffer #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       instruc_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       instruc_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [OPC_W-1:0]         opcode,
  output logic [FUNCT_W-1:0]       funct,
  output logic [INSTR_W-OPC_W-1:0] offset,
  output logic [REG_W-1:0]         fop1,
  output logic [REG_W-1:0]         fop2,
  output logic [1:0]               occupancy
);

  localparam int unsigned OFF_W = INSTR_W - OPC_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]   main_addr_q, main_addr_d;
  logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
  logic                in_fire, out_fire;

  // Handshake flags depend only on registered state, so in_ready never combines out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_instr_q <= '0;
      main_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

  // Next-state and entry movement; flush overrides everything, including a same-cycle accept
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    if (flush) begin
      state_d      = EMPTY;
      main_instr_d = '0;
      main_addr_d  = '0;
      skid_instr_d = '0;
      skid_addr_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            main_instr_d = instruc_in;
            main_addr_d  = addr_in;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_instr_d = instruc_in;
            main_addr_d  = addr_in;
          end else if (in_fire) begin
            state_d      = FULL;
            skid_instr_d = instruc_in;
            skid_addr_d  = addr_in;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_addr_d  = skid_addr_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Head fields are slices of the main entry, gated to zero while nothing is held
  always_comb begin
    instruc_out = '0;
    addr_out    = '0;
    opcode      = '0;
    funct       = '0;
    offset      = '0;
    fop1        = '0;
    fop2        = '0;
    if (out_valid) begin
      instruc_out = main_instr_q;
      addr_out    = main_addr_q;
      opcode      = main_instr_q[INSTR_W-1 -: OPC_W];
      funct       = main_instr_q[FUNCT_W-1:0];
      offset      = main_instr_q[OFF_W-1:0];
      fop1        = main_instr_q[INSTR_W-OPC_W-1 -: REG_W];
      fop2        = main_instr_q[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    end
  end

  always_comb begin
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ifid_pipe_buffer.sv
// Directed self-checking bench for ifid_pipe_buffer (default build plus a 32-bit build).
module tb_ifid_pipe_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] instruc_in, instruc_out;
  logic [7:0]  addr_in, addr_out;
  logic [3:0]  opcode, funct, fop1, fop2;
  logic [11:0] offset;
  logic [1:0]  occupancy;

  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [31:0] w_instruc_in, w_instruc_out;
  logic [7:0]  w_addr_in, w_addr_out;
  logic [5:0]  w_opcode;
  logic [3:0]  w_funct;
  logic [25:0] w_offset;
  logic [4:0]  w_fop1, w_fop2;
  logic [1:0]  w_occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifid_pipe_buffer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruc_in(instruc_in), .addr_in(addr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instruc_out(instruc_out),
    .addr_out(addr_out), .opcode(opcode), .funct(funct), .offset(offset),
    .fop1(fop1), .fop2(fop2), .occupancy(occupancy)
  );

  ifid_pipe_buffer #(.INSTR_W(32), .ADDR_W(8), .OPC_W(6), .REG_W(5), .FUNCT_W(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .instruc_in(w_instruc_in), .addr_in(w_addr_in), .flush(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b0), .instruc_out(w_instruc_out),
    .addr_out(w_addr_out), .opcode(w_opcode), .funct(w_funct), .offset(w_offset),
    .fop1(w_fop1), .fop2(w_fop2), .occupancy(w_occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ins, input logic [7:0] adr);
    in_valid   = 1'b1;
    instruc_in = ins;
    addr_in    = adr;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instruc_in = '0; addr_in = '0;
    w_in_valid = 1'b0; w_instruc_in = '0; w_addr_in = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occ",       64'(occupancy), 64'd0);
    check("rst_instr",     64'(instruc_out), 64'd0);
    check("rst_offset",    64'(offset),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single instruction and field decode
    step();
    push(16'h1234, 8'h05);
    step();
    in_valid = 1'b0;
    check("dec_valid",  64'(out_valid), 64'd1);
    check("dec_opcode", 64'(opcode),    64'h1);
    check("dec_fop1",   64'(fop1),      64'h2);
    check("dec_fop2",   64'(fop2),      64'h3);
    check("dec_funct",  64'(funct),     64'h4);
    check("dec_offset", 64'(offset),    64'h234);
    check("dec_addr",   64'(addr_out),  64'h05);
    check("dec_occ",    64'(occupancy), 64'd1);
    out_ready = 1'b1;
    step();
    check("drain_occ", 64'(occupancy), 64'd0);

    // Backpressure: fill both entries, third push refused
    out_ready = 1'b0;
    push(16'hA001, 8'h10);
    step();
    push(16'hB002, 8'h11);
    step();
    check("full_occ",      64'(occupancy),   64'd2);
    check("full_in_ready", 64'(in_ready),    64'd0);
    check("full_head",     64'(instruc_out), 64'hA001);
    push(16'hC003, 8'h12);
    step();
    check("full_hold_occ",  64'(occupancy),   64'd2);
    check("full_hold_head", 64'(instruc_out), 64'hA001);
    out_ready = 1'b1;
    step();
    check("bp_head_b", 64'(instruc_out), 64'hB002);
    check("bp_addr_b", 64'(addr_out),    64'h11);
    check("bp_occ_b",  64'(occupancy),   64'd1);
    step();
    in_valid = 1'b0;
    check("bp_head_c", 64'(instruc_out), 64'hC003);
    check("bp_addr_c", 64'(addr_out),    64'h12);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Streaming at one per cycle
    for (int i = 0; i < 10; i++) begin
      push(16'h5000 + 16'(i), 8'(8'h40 + i));
      step();
      check("stream_head", 64'(instruc_out), 64'(16'h5000 + 16'(i)));
      check("stream_occ",  64'(occupancy),   64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", 64'(occupancy), 64'd0);

    // Flush while FULL with a simultaneous push
    out_ready = 1'b0;
    push(16'h1111, 8'h21);
    step();
    push(16'h2222, 8'h22);
    step();
    push(16'h3333, 8'h23);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid",    64'(out_valid),   64'd0);
    check("fl_occ",      64'(occupancy),   64'd0);
    check("fl_in_ready", 64'(in_ready),    64'd1);
    check("fl_instr",    64'(instruc_out), 64'd0);
    check("fl_opcode",   64'(opcode),      64'd0);
    check("fl_fields",   64'({funct, fop1, fop2, offset}), 64'd0);
    step();
    check("fl_lost", 64'(out_valid), 64'd0);

    // Async reset between edges while FULL
    push(16'h4444, 8'h31);
    step();
    push(16'h5555, 8'h32);
    step();
    in_valid = 1'b0;
    check("ar_pre_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_occ",   64'(occupancy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(16'h6666, 8'h33);
    step();
    in_valid = 1'b0;
    check("ar_first_accept", 64'(instruc_out), 64'h6666);

    // Wide build decode
    w_in_valid = 1'b1; w_instruc_in = 32'hFC00_0000; w_addr_in = 8'h77;
    step();
    w_in_valid = 1'b0;
    check("w32_valid",  64'(w_out_valid), 64'd1);
    check("w32_opcode", 64'(w_opcode),    64'h3F);
    check("w32_offset", 64'(w_offset),    64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end

endmodule

// File: doc/ifid_pipe_buffer.md
Name: ifid_pipe_buffer

Overview:
- Clocked, parametrised IF/ID pipeline buffer that replaces the combinational IF/ID pass-through.
- Holds up to two fetched instructions (main + skid entry) with a valid/ready handshake on both sides, so fetch keeps full throughput while decode stalls.
- Supports a flush for taken branches and decodes opcode/funct/offset/operand fields from the head entry.
- Sits between the fetch stage (instruction memory + PC) and the decode/register-read stage.

Parameters:
- INSTR_W, 16, instruction width in bits (>= OPC_W + 2*REG_W + FUNCT_W).
- ADDR_W, 8, instruction address (PC) width.
- OPC_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OPC_W].
- REG_W, 4, operand-field width; fop1 = instr[INSTR_W-OPC_W-1 -: REG_W], fop2 = the next REG_W bits below fop1.
- FUNCT_W, 4, funct width; funct = instr[FUNCT_W-1:0].

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset, asynchronous, active-high.
- in_valid, input, 1, fetch presents an instruction.
- in_ready, output, 1, buffer can accept this cycle.
- instruc_in, input, INSTR_W, fetched instruction.
- addr_in, input, ADDR_W, PC of the fetched instruction.
- flush, input, 1, discard all held and incoming entries.
- out_valid, output, 1, head entry is valid.
- out_ready, input, 1, decode consumes the head this cycle.
- instruc_out, output, INSTR_W, head instruction.
- addr_out, output, ADDR_W, head PC.
- opcode, output, OPC_W, head opcode field.
- funct, output, FUNCT_W, head funct field.
- offset, output, INSTR_W-OPC_W, head offset field, instr[INSTR_W-OPC_W-1:0].
- fop1, output, REG_W, head operand 1 field.
- fop2, output, REG_W, head operand 2 field.
- occupancy, output, 2, number of valid entries (0..2).

Behaviour:
- Reset (async, rst=1): state EMPTY; main and skid data cleared to 0; out_valid=0; in_ready=1; occupancy=0; all field outputs 0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = (state != FULL); it depends only on registered state, never on out_ready.
  - out_valid = (state != EMPTY).
- States and transitions (all at the clock edge):
  - EMPTY: in_fire -> ONE, main <= input.
  - ONE with in_fire & out_fire: stays ONE, main <= input.
  - ONE with in_fire & !out_fire: -> FULL, skid <= input.
  - ONE with !in_fire & out_fire: -> EMPTY.
  - FULL with out_fire: -> ONE, main <= skid. No input is accepted in FULL.
  - Any other case: hold state and data.
- Order is strictly FIFO; an entry is never duplicated or dropped except by flush.
- Latency: an instruction accepted in cycle N is visible at the outputs in cycle N+1. Sustained throughput is 1 per cycle when out_ready=1.
- flush=1 has top priority:
  - Next state is EMPTY and main/skid are cleared.
  - An instruction handshaked in the same cycle (in_fire) is discarded.
  - out_fire in the same cycle is still a valid consume of the old head; decode owns that decision.
- Field outputs are combinational slices of the main register, forced to 0 whenever out_valid=0.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The first accept is possible on the first rising edge after deassertion.

Test Plan:
- Reset, then in_valid=1 with instruc_in=16'h1234, addr_in=8'h05 -> next cycle out_valid=1, opcode=4'h1, fop1=4'h2, fop2=4'h3, funct=4'h4, offset=12'h234, addr_out=8'h05.
- out_ready=0 while pushing 16'hA001 then 16'hB002 -> occupancy=2, in_ready=0; a third push of 16'hC003 is not accepted. Raise out_ready -> outputs A001, B002 on consecutive cycles, then C003.
- Continuous streaming of 10 instructions with out_ready=1 -> one output per cycle, in order, occupancy stays 1.
- FULL state, then flush=1 together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, all field outputs 0, the pushed instruction is lost.
- Assert rst asynchronously between edges while FULL -> out_valid and occupancy go to 0 immediately, before the next edge.
- Parameter build INSTR_W=32, OPC_W=6, REG_W=5, with instr 32'hFC00_0000 -> opcode=6'h3F, offset=26'h0.
